// File: rtl/ifetch_unit_pkg.sv
// Shared definitions for the instruction-fetch unit: next-PC select codes,
// reset PC and FSM state encoding.
package ifetch_unit_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_3000;
  localparam logic [XLEN-1:0] PC_STEP  = 32'h0000_0004;

  typedef enum logic [1:0] {
    NPC_N   = 2'b00,
    NPC_BEQ = 2'b01,
    NPC_J   = 2'b10,
    NPC_JR  = 2'b11
  } npc_sel_e;

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_HOLD  = 2'b01,
    ST_ERR   = 2'b10
  } state_e;

  function automatic logic is_aligned(input logic [1:0] low_bits);
    return (low_bits == 2'b00);
  endfunction

endpackage

// File: rtl/ifetch_unit_npc_calc.sv
// Combinational next-PC generator: sequential, branch, jump and register
// targets selected by the controller's s_npc code.
module npc_calc
  import ifetch_unit_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic [1:0]      s_npc,
  input  logic [XLEN-1:0] imm32,
  input  logic [XLEN-1:0] rs_data,
  input  logic [25:0]     jump_index,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] npc
);

  logic [XLEN-1:0] branch_target;
  logic [XLEN-1:0] jump_target;
  npc_sel_e        sel;

  // All additions wrap modulo 2^32; no overflow is flagged.
  assign pc_plus4      = pc + PC_STEP;
  assign branch_target = pc_plus4 + (imm32 << 2);
  assign jump_target   = {pc_plus4[31:28], jump_index, 2'b00};
  assign sel           = npc_sel_e'(s_npc);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    npc = pc_plus4;
    unique case (sel)
      NPC_N:   npc = pc_plus4;
      NPC_BEQ: npc = branch_target;
      NPC_J:   npc = jump_target;
      NPC_JR:  npc = rs_data;
    endcase
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch unit: issues one fetch per instruction, holds the word
// until the core commits it, then advances the PC or traps on misalignment.
module ifetch_unit
  import ifetch_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      s_npc,
  input  logic [XLEN-1:0] imm32,
  input  logic [XLEN-1:0] rs_data,
  input  logic            commit,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            addr_err
);

  state_e          state;
  state_e          state_next;
  logic [XLEN-1:0] npc;
  logic            take_ack;
  logic            take_commit;
  logic            npc_ok;

  npc_calc u_npc_calc (
    .pc         (pc),
    .s_npc      (s_npc),
    .imm32      (imm32),
    .rs_data    (rs_data),
    .jump_index (instr[25:0]),
    .pc_plus4   (pc_plus4),
    .npc        (npc)
  );

  // Strobes outside their owning state are ignored by construction.
  assign take_ack    = (state == ST_FETCH) && imem_ack;
  assign take_commit = (state == ST_HOLD) && commit;
  assign npc_ok      = is_aligned(npc[1:0]);

  assign imem_req    = (state == ST_FETCH);
  assign instr_valid = (state == ST_HOLD);
  assign imem_addr   = pc;

  always_comb begin
    state_next = state;
    unique case (state)
      ST_FETCH: if (take_ack) state_next = ST_HOLD;
      ST_HOLD:  if (take_commit) state_next = npc_ok ? ST_FETCH : ST_ERR;
      ST_ERR:   state_next = ST_ERR;
      default:  state_next = ST_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_FETCH;
      pc       <= RESET_PC;
      instr    <= '0;
      addr_err <= 1'b0;
    end else begin
      state <= state_next;
      if (take_ack) begin
        instr <= imem_rdata;
      end
      if (take_commit) begin
        if (npc_ok) begin
          pc <= npc;
        end else begin
          addr_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: acts as instruction memory, scoreboards
// fetched words against an independent next-PC model.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  s_npc;
  logic [31:0] imm32;
  logic [31:0] rs_data;
  logic        commit;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        addr_err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } sb_t;

  sb_t         sb[$];
  logic [31:0] exp_pc;
  logic [31:0] exp_instr;

  always #5 clk = ~clk;

  ifetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_npc       (s_npc),
    .imm32       (imm32),
    .rs_data     (rs_data),
    .commit      (commit),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .addr_err    (addr_err)
  );

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_npc(input logic [31:0] cur_pc, input logic [1:0] sel,
                                            input logic [31:0] imm, input logic [31:0] rs,
                                            input logic [31:0] ins);
    logic [31:0] seq;
    seq = cur_pc + 32'd4;
    case (sel)
      2'b00:   return seq;
      2'b01:   return seq + imm * 32'd4;
      2'b10:   return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 32'd4);
      default: return rs;
    endcase
  endfunction

  // Wait lat cycles in FETCH (optionally poking commit), then return data.
  task automatic do_fetch(input int lat, input logic [31:0] data, input bit poke_commit);
    sb_t e;
    for (int i = 0; i < lat; i++) begin
      commit  = poke_commit;
      s_npc   = 2'b11;
      rs_data = 32'h0000_3002;
      step();
      commit = 1'b0;
      check("fetch_wait_req", {31'b0, imem_req}, 32'd1);
      check("fetch_wait_valid", {31'b0, instr_valid}, 32'd0);
      check("fetch_wait_pc", pc, exp_pc);
    end
    check("fetch_addr", imem_addr, exp_pc);
    imem_ack   = 1'b1;
    imem_rdata = data;
    sb.push_back('{exp_pc, data});
    step();
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    check("hold_valid", {31'b0, instr_valid}, 32'd1);
    check("hold_req", {31'b0, imem_req}, 32'd0);
    if (sb.size() == 0) begin
      check("sb_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("sb_instr", instr, e.instr);
      check("sb_pc", pc, e.pc);
      exp_instr = e.instr;
    end
  endtask

  // Idle in HOLD with a stray ack, then commit and check the outcome.
  task automatic do_commit(input logic [1:0] sel, input logic [31:0] imm, input logic [31:0] rs);
    logic [31:0] n;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 1'b0;
    check("hold_ignores_ack", instr, exp_instr);
    check("hold_still_valid", {31'b0, instr_valid}, 32'd1);
    n       = model_npc(exp_pc, sel, imm, rs, exp_instr);
    s_npc   = sel;
    imm32   = imm;
    rs_data = rs;
    commit  = 1'b1;
    step();
    commit = 1'b0;
    check("post_commit_valid", {31'b0, instr_valid}, 32'd0);
    if (n[1:0] != 2'b00) begin
      check("err_flag", {31'b0, addr_err}, 32'd1);
      check("err_req", {31'b0, imem_req}, 32'd0);
      check("err_pc", pc, exp_pc);
    end else begin
      exp_pc = n;
      check("next_addr", imem_addr, n);
      check("next_req", {31'b0, imem_req}, 32'd1);
      check("no_err", {31'b0, addr_err}, 32'd0);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    s_npc      = 2'b00;
    imm32      = '0;
    rs_data    = '0;
    commit     = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    exp_instr  = '0;
    step();
    step();
    rst_n  = 1'b1;
    exp_pc = 32'h0000_3000;
    check("rst_pc", pc, 32'h0000_3000);
    check("rst_instr", instr, 32'h0);
    check("rst_err", {31'b0, addr_err}, 32'd0);
    check("rst_req", {31'b0, imem_req}, 32'd1);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_pc_plus4", pc_plus4, 32'h0000_3004);

    // First fetch at the reset PC.
    do_fetch(1, 32'h2010_0005, 1'b0);
    check("first_instr", instr, 32'h2010_0005);
    check("first_pc_plus4", pc_plus4, 32'h0000_3004);
    do_commit(2'b00, 32'h0, 32'h0);
    do_fetch(2, 32'h1111_0000, 1'b0);
    do_commit(2'b00, 32'h0, 32'h0);
    check("seq_to_3008", pc, 32'h0000_3008);

    // Backward branch from 0x3008.
    do_fetch(0, 32'h1000_FFFE, 1'b0);
    do_commit(2'b01, 32'hFFFF_FFFE, 32'h0);
    check("beq_back", imem_addr, 32'h0000_3004);
    do_fetch(0, 32'h2222_0000, 1'b0);
    do_commit(2'b00, 32'h0, 32'h0);
    do_fetch(3, 32'h3333_0000, 1'b0);
    do_commit(2'b00, 32'h0, 32'h0);
    do_fetch(0, 32'h4444_0000, 1'b0);
    do_commit(2'b00, 32'h0, 32'h0);
    check("seq_to_3010", pc, 32'h0000_3010);

    // Jump at 0x3010.
    do_fetch(1, 32'h0C00_0C40, 1'b0);
    do_commit(2'b10, 32'h0, 32'h0);
    check("jump_target", imem_addr, 32'h0000_3100);

    // Slow memory; commit pulses during FETCH must be ignored.
    do_fetch(5, 32'h5555_0000, 1'b1);
    check("slow_pc_kept", pc, 32'h0000_3100);
    check("slow_no_err", {31'b0, addr_err}, 32'd0);

    // Wrap-around from the top of the address space.
    do_commit(2'b11, 32'h0, 32'hFFFF_FFFC);
    do_fetch(0, 32'h6666_0000, 1'b0);
    check("top_pc_plus4", pc_plus4, 32'h0000_0000);
    do_commit(2'b00, 32'h0, 32'h0);
    check("wrap_pc", pc, 32'h0000_0000);

    // Reset while holding at 0x3020.
    do_fetch(0, 32'h7777_0000, 1'b0);
    do_commit(2'b11, 32'h0, 32'h0000_3020);
    do_fetch(1, 32'h8888_0000, 1'b0);
    check("hold_at_3020", pc, 32'h0000_3020);
    rst_n = 1'b0;
    step();
    rst_n  = 1'b1;
    exp_pc = 32'h0000_3000;
    check("hold_rst_pc", pc, 32'h0000_3000);
    check("hold_rst_valid", {31'b0, instr_valid}, 32'd0);
    check("hold_rst_req", {31'b0, imem_req}, 32'd1);
    check("hold_rst_instr", instr, 32'h0);

    // Stale ack in the first post-reset cycle is taken for 0x3000.
    do_fetch(0, 32'h9999_0000, 1'b0);

    // Misaligned register target traps.
    do_commit(2'b11, 32'h0, 32'h0000_3002);
    for (int i = 0; i < 4; i++) begin
      imem_ack = 1'b1;
      commit   = 1'b1;
      s_npc    = 2'b00;
      step();
      check("err_sticky", {31'b0, addr_err}, 32'd1);
      check("err_no_req", {31'b0, imem_req}, 32'd0);
      check("err_no_valid", {31'b0, instr_valid}, 32'd0);
      check("err_pc_held", pc, 32'h0000_3000);
    end
    imem_ack = 1'b0;
    commit   = 1'b0;
    rst_n    = 1'b0;
    step();
    rst_n = 1'b1;
    check("err_cleared", {31'b0, addr_err}, 32'd0);
    check("err_rst_req", {31'b0, imem_req}, 32'd1);
    check("sb_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1; reset is synchronous and active-low.
REQ-003 SHALL have port s_npc, input, 2, next-PC select from controller (00 N_nPC, 01 BEQ_nPC, 10 J_nPC, 11 JR_nPC).
REQ-004 SHALL have port imm32, input, 32, extended immediate for branch offset.
REQ-005 SHALL have port rs_data, input, 32, register rs value; the JR target.
REQ-006 SHALL have port commit, input, 1, pulse meaning the current instruction has executed and its s_npc/imm32/rs_data are valid.
REQ-007 SHALL have port imem_req, output, 1, fetch request to instruction memory.
REQ-008 SHALL have port imem_addr, output, 32, fetch address; always equals pc.
REQ-009 SHALL have port imem_ack, input, 1, memory response strobe; latency 1..N cycles.
REQ-010 SHALL have port imem_rdata, input, 32, instruction word, valid when imem_ack=1.
REQ-011 SHALL have ports instr_valid (output, 1), instr (output, 32), pc (output, 32), pc_plus4 (output, 32; used as link value by JAL).
REQ-012 SHALL have port addr_err, output, 1, sticky misaligned-target flag.

Function
REQ-013 SHALL implement FSM states FETCH, HOLD, ERR.
REQ-014 In FETCH: imem_req=1, instr_valid=0; on imem_ack=1, latch imem_rdata into instr and go to HOLD next cycle.
REQ-015 In HOLD: imem_req=0, instr_valid=1, instr stable; on commit=1, load pc with next PC and go to FETCH next cycle.
REQ-016 Minimum issue interval SHALL be 2 cycles (ack in cycle t, instr_valid in t+1, commit in t+1, new request in t+2).
REQ-017 commit outside HOLD and imem_ack outside FETCH SHALL be ignored.
REQ-018 pc_plus4 SHALL equal pc+4, combinational, modulo 2^32.
REQ-019 Next PC for N_nPC SHALL be pc+4.
REQ-020 Next PC for BEQ_nPC SHALL be pc+4+(imm32<<2), 32-bit wrap-around, no overflow detection.
REQ-021 Next PC for J_nPC SHALL be {pc_plus4[31:28], instr[25:0], 2'b00}.
REQ-022 Next PC for JR_nPC SHALL be rs_data.
REQ-023 If the selected next PC has bits [1:0] != 0 at commit, SHALL leave pc unchanged, set addr_err=1, and enter ERR.
REQ-024 In ERR: imem_req=0 and instr_valid=0; remain there until reset.
REQ-025 pc+4 from 0xFFFF_FFFC SHALL wrap to 0x0000_0000 without error.

Reset
REQ-026 With rst_n=0 at a clock edge, SHALL set pc=0x0000_3000, instr=0, addr_err=0, and state=FETCH.
REQ-027 imem_req=1 SHALL be asserted in the first cycle after reset release.
REQ-028 Reset during an outstanding fetch SHALL abandon it; a stale imem_ack arriving in the first FETCH cycle after reset is accepted as the response for 0x0000_3000 (memory must flush on reset).

Structure
REQ-029 s_npc encodings, the reset PC constant and the state encodings SHALL live in the shared def.v.
REQ-030 Next-PC computation SHALL be one combinational sub-module, npc_calc.

Verification
REQ-031 Reset, ack after 1 cycle with 0x2010_0005 -> imem_addr=0x3000, instr_valid next cycle, instr=0x2010_0005, pc_plus4=0x3004.
REQ-032 HOLD at pc=0x3008, commit with s_npc=01 and imm32=0xFFFF_FFFE -> next imem_addr=0x3004.
REQ-033 pc=0x3010, instr=0x0C00_0C40, commit with s_npc=10 -> next imem_addr=0x0000_3100.
REQ-034 commit with s_npc=11 and rs_data=0x0000_3002 -> addr_err=1, pc stays, imem_req=0 persists until rst_n=0.
REQ-035 imem_ack delayed 5 cycles, commit pulsed during FETCH -> commit ignored, pc unchanged, instr_valid only after ack.
REQ-036 rst_n=0 asserted while in HOLD at pc=0x3020 -> next cycle pc=0x3000, instr_valid=0, imem_req=1.
